// File: rtl/timer_pkg.sv
// Shared definitions for the N-channel counter/timer: mode and register
// select encodings and the CTRL register layout.
package timer_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned REG_W  = 2;
    localparam int unsigned CTRL_W = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IE_BIT   = 3;

    typedef enum logic [MODE_W-1:0] {
        TM_ONESHOT  = 2'd0,
        TM_PERIODIC = 2'd1,
        TM_SQUARE   = 2'd2,
        TM_FREERUN  = 2'd3
    } tm_mode_e;

    typedef enum logic [REG_W-1:0] {
        TR_LOAD = 2'd0,
        TR_CTRL = 2'd1,
        TR_ICLR = 2'd2,
        TR_RSVD = 2'd3
    } tr_reg_e;

    // Packed so that the struct overlays CTRL bits [3:0] directly.
    typedef struct packed {
        logic     ie;
        tm_mode_e mode;
        logic     en;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input logic [CTRL_W-1:0] v);
        return ctrl_t'(v);
    endfunction

endpackage

// File: rtl/counter_timer_n_if.sv
// MIO peripheral port of the counter/timer.
//   counter_we  : single-cycle write strobe
//   counter_ch  : channel select for write and read
//   counter_reg : register select (LOAD/CTRL/ICLR/reserved)
//   counter_val : write data
//   counter_out : count of the selected channel (combinational read)
interface counter_timer_n_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CH_W  = 2
);
    logic             counter_we;
    logic [CH_W-1:0]  counter_ch;
    logic [1:0]       counter_reg;
    logic [WIDTH-1:0] counter_val;
    logic [WIDTH-1:0] counter_out;

    modport master (
        output counter_we, counter_ch, counter_reg, counter_val,
        input  counter_out
    );

    modport slave (
        input  counter_we, counter_ch, counter_reg, counter_val,
        output counter_out
    );
endinterface

// File: rtl/timer_chan.sv
// One timer channel: reload/count/CTRL/pending registers, tick edge detect
// and the four counting modes.
//   clk, rst        : clock, synchronous active-high reset
//   tick_in         : divider tap, counted on its rising edge
//   wr_load/ctrl/iclr : decoded single-cycle writes to this channel
//   wr_val          : write data
//   count           : current count
//   chan_out        : expiry/waveform output
//   irq_c           : pending and enabled interrupt
module timer_chan
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             wr_load,
    input  logic             wr_ctrl,
    input  logic             wr_iclr,
    input  logic [WIDTH-1:0] wr_val,
    output logic [WIDTH-1:0] count,
    output logic             chan_out,
    output logic             irq_c
);

    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_q,  count_d;
    ctrl_t            ctrl_q,   ctrl_d;
    logic             pend_q,   pend_d;
    logic             out_q,    out_d;
    logic             pulse_q,  pulse_d;   // out_q is a one-cycle pulse
    logic             tick_q;
    logic             tick;
    logic             expire;

    assign tick = tick_in & ~tick_q;

    // Next-state: writes take priority over (and swallow) a coincident tick,
    // except ICLR, which lets an expiry in the same cycle re-set pend.
    always_comb begin
        reload_d = reload_q;
        count_d  = count_q;
        ctrl_d   = ctrl_q;
        pend_d   = pend_q;
        out_d    = pulse_q ? 1'b0 : out_q;
        pulse_d  = 1'b0;
        expire   = 1'b0;

        if (wr_load) begin
            reload_d = wr_val;
            count_d  = wr_val;
            out_d    = 1'b0;
        end else if (wr_ctrl) begin
            ctrl_d = ctrl_decode(wr_val[CTRL_W-1:0]);
        end else if (tick && ctrl_q.en &&
                     (ctrl_q.mode == TM_FREERUN || count_q != '0)) begin
            case (ctrl_q.mode)
                TM_ONESHOT: begin
                    count_d = count_q - WIDTH'(1);
                    if (count_q == WIDTH'(1)) begin
                        out_d     = 1'b1;
                        ctrl_d.en = 1'b0;
                        expire    = 1'b1;
                    end
                end
                TM_PERIODIC, TM_SQUARE: begin
                    if (count_q == WIDTH'(1)) begin
                        count_d = reload_q;
                        expire  = 1'b1;
                        if (ctrl_q.mode == TM_PERIODIC) begin
                            out_d   = 1'b1;
                            pulse_d = 1'b1;
                        end else begin
                            out_d = ~out_q;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                TM_FREERUN: begin
                    count_d = count_q + WIDTH'(1);
                    if (&count_q) begin
                        out_d   = 1'b1;
                        pulse_d = 1'b1;
                        expire  = 1'b1;
                    end
                end
            endcase
        end

        if (wr_iclr) begin
            pend_d = 1'b0;
        end
        if (expire && ctrl_q.ie) begin
            pend_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
            count_q  <= '0;
            ctrl_q   <= '0;
            pend_q   <= 1'b0;
            out_q    <= 1'b0;
            pulse_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
            ctrl_q   <= ctrl_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
            pulse_q  <= pulse_d;
            tick_q   <= tick_in;
        end
    end

    assign count    = count_q;
    assign chan_out = out_q;
    assign irq_c    = pend_q & ctrl_q.ie;

endmodule

// File: rtl/counter_timer_n.sv
// Parametrised N-channel timer: write decode onto CH timer_chan instances,
// combinational read mux of the selected count and the combined interrupt.
//   clk, rst : clock, synchronous active-high reset
//   bus      : MIO peripheral port (slave side)
//   tick_in  : per-channel divider taps
//   chan_out : per-channel expiry/waveform outputs
//   irq      : OR of all pending-and-enabled interrupts
module counter_timer_n
    import timer_pkg::*;
#(
    parameter int unsigned CH    = 3,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CH_W  = 2
) (
    input  logic          clk,
    input  logic          rst,
    counter_timer_n_if.slave bus,
    input  logic [CH-1:0] tick_in,
    output logic [CH-1:0] chan_out,
    output logic          irq
);

    tr_reg_e          reg_sel;
    logic [WIDTH-1:0] count_a [CH];
    logic [CH-1:0]    irq_vec;
    logic [WIDTH-1:0] counter_out_c;

    assign reg_sel = tr_reg_e'(bus.counter_reg);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        logic hit;
        assign hit = bus.counter_we && (bus.counter_ch == CH_W'(g));

        timer_chan #(.WIDTH(WIDTH)) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick_in  (tick_in[g]),
            .wr_load  (hit && reg_sel == TR_LOAD),
            .wr_ctrl  (hit && reg_sel == TR_CTRL),
            .wr_iclr  (hit && reg_sel == TR_ICLR),
            .wr_val   (bus.counter_val),
            .count    (count_a[g]),
            .chan_out (chan_out[g]),
            .irq_c    (irq_vec[g])
        );
    end

    // Read mux; unimplemented channel numbers read as zero.
    always_comb begin
        counter_out_c = '0;
        for (int i = 0; i < CH; i++) begin
            if (bus.counter_ch == CH_W'(i)) begin
                counter_out_c = count_a[i];
            end
        end
    end

    assign bus.counter_out = counter_out_c;
    assign irq             = |irq_vec;

endmodule

// File: tb/tb_counter_timer_n.sv
// Bench for counter_timer_n: directed test-plan sequence with literal
// expectations, then randomized traffic, all checked against a per-cycle
// behavioural model of the timer rules.
module tb_counter_timer_n;

    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] tick_in;
    logic [CH-1:0] chan_out;
    logic          irq;

    counter_timer_n_if #(.WIDTH(32), .CH_W(2)) bus ();

    counter_timer_n #(.CH(CH), .WIDTH(32), .CH_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .tick_in  (tick_in),
        .chan_out (chan_out),
        .irq      (irq)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_count  [CH];
    logic [31:0] m_reload [CH];
    bit          m_en     [CH];
    bit [1:0]    m_mode   [CH];
    bit          m_ie     [CH];
    bit          m_pend   [CH];
    bit          m_level  [CH];   // held level (one-shot done / square phase)
    int          m_pulse_at [CH]; // cycle in which a one-cycle pulse is shown
    bit          m_prev   [CH];
    int          cyc = 0;

    always @(posedge clk) begin
        cyc++;
        for (int c = 0; c < CH; c++) begin
            bit rising, wr, expired;
            rising = tick_in[c] && !m_prev[c];
            m_prev[c] = tick_in[c];
            wr = bus.counter_we && (int'(bus.counter_ch) == c);
            expired = 1'b0;
            if (rst) begin
                m_count[c] = 0; m_reload[c] = 0; m_en[c] = 0; m_mode[c] = 0;
                m_ie[c] = 0; m_pend[c] = 0; m_level[c] = 0; m_pulse_at[c] = -1;
                m_prev[c] = 0;
            end else if (wr && bus.counter_reg == 2'd0) begin
                m_count[c] = bus.counter_val;
                m_reload[c] = bus.counter_val;
                m_level[c] = 0;
                m_pulse_at[c] = -1;
            end else if (wr && bus.counter_reg == 2'd1) begin
                m_en[c]   = bus.counter_val[0];
                m_mode[c] = bus.counter_val[2:1];
                m_ie[c]   = bus.counter_val[3];
            end else begin
                if (rising && m_en[c]) begin
                    if (m_mode[c] == 2'd3) begin
                        m_count[c] = m_count[c] + 32'd1;
                        if (m_count[c] == 0) begin
                            expired = 1; m_level[c] = 0; m_pulse_at[c] = cyc;
                        end
                    end else if (m_count[c] != 0) begin
                        m_count[c] = m_count[c] - 32'd1;
                        if (m_count[c] == 0) begin
                            expired = 1;
                            if (m_mode[c] == 2'd0) begin
                                m_level[c] = 1; m_en[c] = 0;
                            end else begin
                                m_count[c] = m_reload[c];
                                if (m_mode[c] == 2'd1) begin
                                    m_level[c] = 0; m_pulse_at[c] = cyc;
                                end else begin
                                    m_level[c] = !m_level[c];
                                end
                            end
                        end
                    end
                end
                if (wr && bus.counter_reg == 2'd2) m_pend[c] = 0;
                if (expired && m_ie[c]) m_pend[c] = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            logic [31:0]   e_out;
            logic [CH-1:0] e_chan;
            logic          e_irq;
            e_out = (int'(bus.counter_ch) < CH) ? m_count[int'(bus.counter_ch)] : 32'd0;
            e_irq = 1'b0;
            for (int c = 0; c < CH; c++) begin
                e_chan[c] = m_level[c] | (m_pulse_at[c] == cyc);
                e_irq = e_irq | (m_pend[c] & m_ie[c]);
            end
            check("model counter_out", bus.counter_out, e_out);
            check("model chan_out", 32'(chan_out), 32'(e_chan));
            check("model irq", 32'(irq), 32'(e_irq));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int c, input int r, input logic [31:0] v);
        step();
        bus.counter_we  = 1'b1;
        bus.counter_ch  = 2'(c);
        bus.counter_reg = 2'(r);
        bus.counter_val = v;
        step();
        bus.counter_we  = 1'b0;
    endtask

    task automatic tick_pulse(input int c);
        step();
        tick_in[c] = 1'b1;
        step();
        tick_in[c] = 1'b0;
    endtask

    task automatic rd_check(input int c, input string name, input logic [31:0] exp);
        bus.counter_ch = 2'(c);
        #1;
        check(name, bus.counter_out, exp);
    endtask

    logic [3:0] sq_exp;

    initial begin
        rst = 1'b1;
        tick_in = '0;
        bus.counter_we = 1'b0;
        bus.counter_ch = '0;
        bus.counter_reg = '0;
        bus.counter_val = '0;
        step(); step();
        rst = 1'b0;
        chk_on = 1'b1;

        // reset state
        for (int c = 0; c < CH; c++) rd_check(c, "reset count", 32'd0);
        check("reset chan_out", 32'(chan_out), 32'd0);
        check("reset irq", 32'(irq), 32'd0);

        // ch0 one-shot
        wr(0, 0, 32'd3);
        wr(0, 1, 32'h9);
        tick_pulse(0); rd_check(0, "oneshot t1", 32'd2);
        tick_pulse(0); rd_check(0, "oneshot t2", 32'd1);
        tick_pulse(0); rd_check(0, "oneshot t3", 32'd0);
        check("oneshot chan_out", 32'(chan_out[0]), 32'd1);
        check("oneshot irq", 32'(irq), 32'd1);
        tick_pulse(0); rd_check(0, "oneshot extra tick", 32'd0);
        check("oneshot held", 32'(chan_out[0]), 32'd1);
        wr(0, 2, 32'd0);
        check("oneshot iclr irq", 32'(irq), 32'd0);

        // ch1 periodic
        wr(1, 0, 32'd2);
        wr(1, 1, 32'h3);
        for (int i = 1; i <= 6; i++) begin
            tick_pulse(1);
            rd_check(1, "periodic count", (i % 2 == 1) ? 32'd1 : 32'd2);
            check("periodic pulse", 32'(chan_out[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        step();
        check("periodic pulse drop", 32'(chan_out[1]), 32'd0);

        // ch2 square, period 4 ticks
        wr(2, 0, 32'd2);
        wr(2, 1, 32'h5);
        sq_exp = 4'b0101;
        for (int i = 1; i <= 8; i++) begin
            tick_pulse(2);
            if (i % 2 == 0) check("square level", 32'(chan_out[2]), 32'(sq_exp[i/2 - 1]));
        end
        check("square irq off", 32'(irq), 32'd0);

        // ch0 free-run wrap
        wr(0, 0, 32'hFFFF_FFFE);
        wr(0, 1, 32'hF);
        tick_pulse(0); rd_check(0, "freerun t1", 32'hFFFF_FFFF);
        tick_pulse(0); rd_check(0, "freerun wrap", 32'd0);
        check("freerun pulse", 32'(chan_out[0]), 32'd1);
        check("freerun irq", 32'(irq), 32'd1);
        step();
        tick_in[0] = 1'b1;
        repeat (5) step();
        tick_in[0] = 1'b0;
        step();
        rd_check(0, "held tick once", 32'd1);
        wr(0, 2, 32'd0);
        check("freerun iclr", 32'(irq), 32'd0);

        // same-cycle LOAD and tick on ch1: write wins
        step();
        tick_in[1] = 1'b1;
        bus.counter_we = 1'b1; bus.counter_ch = 2'd1;
        bus.counter_reg = 2'd0; bus.counter_val = 32'd10;
        step();
        bus.counter_we = 1'b0;
        tick_in[1] = 1'b0;
        rd_check(1, "load beats tick", 32'd10);

        // same-cycle ICLR and expiry on ch2: set wins
        wr(2, 0, 32'd1);
        wr(2, 1, 32'hB);
        step();
        tick_in[2] = 1'b1;
        bus.counter_we = 1'b1; bus.counter_ch = 2'd2;
        bus.counter_reg = 2'd2; bus.counter_val = 32'd0;
        step();
        bus.counter_we = 1'b0;
        tick_in[2] = 1'b0;
        check("iclr vs expiry irq", 32'(irq), 32'd1);
        wr(2, 2, 32'd0);
        check("iclr after", 32'(irq), 32'd0);

        // reset mid-count
        tick_pulse(1); tick_pulse(1);
        rd_check(1, "pre-reset count", 32'd8);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        for (int c = 0; c < CH; c++) rd_check(c, "mid reset count", 32'd0);
        check("mid reset chan_out", 32'(chan_out), 32'd0);
        check("mid reset irq", 32'(irq), 32'd0);

        // randomized traffic, checked by the model every cycle
        repeat (3000) begin
            step();
            rst = ($urandom_range(0, 999) == 0);
            tick_in = 3'($urandom_range(0, 7));
            bus.counter_we  = ($urandom_range(0, 5) == 0);
            bus.counter_ch  = 2'($urandom_range(0, 3));
            bus.counter_reg = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                bus.counter_val = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                bus.counter_val = 32'($urandom_range(0, 15));
        end
        step();
        bus.counter_we = 1'b0;
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
